// File: rtl/dual_issue_ctrl_if.sv
// Fetch / hazard-unit / issue-pipe bundle for the dual-issue controller.
// The master side drives the offered pair and hazard verdicts; the controller is the slave.
interface dual_issue_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [0:31] in_instr1;
    logic [0:31] in_instr2;
    logic        in_type1;
    logic        in_type2;
    logic [0:31] in_pc;
    logic        stall;
    logic        dependent_stall;
    logic        flush;
    logic [0:1]  instr_dependent_protocol;
    logic        even_valid;
    logic        odd_valid;
    logic [0:31] even_instr;
    logic [0:31] odd_instr;
    logic [0:31] even_pc;
    logic [0:31] odd_pc;
    logic [15:0] stall_cycles;

    modport master (
        output in_valid, in_instr1, in_instr2, in_type1, in_type2, in_pc,
        output stall, dependent_stall, flush,
        input  in_ready, instr_dependent_protocol,
        input  even_valid, odd_valid, even_instr, odd_instr, even_pc, odd_pc,
        input  stall_cycles
    );

    modport slave (
        input  in_valid, in_instr1, in_instr2, in_type1, in_type2, in_pc,
        input  stall, dependent_stall, flush,
        output in_ready, instr_dependent_protocol,
        output even_valid, odd_valid, even_instr, odd_instr, even_pc, odd_pc,
        output stall_cycles
    );
endinterface

// File: rtl/dual_issue_ctrl.sv
// Dual-issue controller: holds one fetched pair and issues it to the even/odd pipes,
// either together or split in program order when the hazard unit reports a dependency.
module dual_issue_ctrl (
    input  logic             clk,
    input  logic             reset,
    dual_issue_ctrl_if.slave bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PAIR   = 2'd1,
        SPLIT1 = 2'd2,
        SPLIT2 = 2'd3
    } state_t;

    state_t            state, state_d;
    logic [0:XLEN-1]   h_instr1, h_instr2, h_pc, h_pc2;
    logic              h_type1, h_type2;

    logic              ready_c, accept_c, stall_inc_c;
    logic              issue1_c, issue2_c, done_c;
    logic [0:1]        protocol_c;
    logic              even_valid_d, odd_valid_d;
    logic [0:XLEN-1]   even_instr_d, odd_instr_d, even_pc_d, odd_pc_d;

    assign h_pc2    = h_pc + XLEN'(4);
    assign accept_c = bus.in_valid & ready_c;

    assign bus.in_ready                 = ready_c;
    assign bus.instr_dependent_protocol = protocol_c;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    // Next state, handshake and next issue values
    always_comb begin
        state_d      = state;
        ready_c      = 1'b0;
        protocol_c   = 2'b00;
        stall_inc_c  = 1'b0;
        issue1_c     = 1'b0;
        issue2_c     = 1'b0;
        done_c       = 1'b0;
        even_valid_d = 1'b0;
        odd_valid_d  = 1'b0;
        even_instr_d = bus.even_instr;
        odd_instr_d  = bus.odd_instr;
        even_pc_d    = bus.even_pc;
        odd_pc_d     = bus.odd_pc;

        case (state)
            IDLE: begin
                ready_c = 1'b1;
                if (bus.in_valid) state_d = PAIR;
            end
            PAIR: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (bus.stall) begin
                    stall_inc_c = 1'b1;
                end else if (bus.dependent_stall) begin
                    stall_inc_c = 1'b1;
                    state_d     = SPLIT1;
                end else begin
                    issue1_c = 1'b1;
                    issue2_c = 1'b1;
                    done_c   = 1'b1;
                end
            end
            SPLIT1: begin
                protocol_c = 2'b01;
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (bus.stall) begin
                    stall_inc_c = 1'b1;
                end else begin
                    issue1_c = 1'b1;
                    state_d  = SPLIT2;
                end
            end
            SPLIT2: begin
                protocol_c = 2'b10;
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (bus.stall) begin
                    stall_inc_c = 1'b1;
                end else begin
                    issue2_c = 1'b1;
                    done_c   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Completing issue frees the hold register for a same-cycle refill
        if (done_c) begin
            ready_c = 1'b1;
            state_d = bus.in_valid ? PAIR : IDLE;
        end

        if (issue1_c) begin
            if (h_type1) begin
                odd_valid_d = 1'b1;
                odd_instr_d = h_instr1;
                odd_pc_d    = h_pc;
            end else begin
                even_valid_d = 1'b1;
                even_instr_d = h_instr1;
                even_pc_d    = h_pc;
            end
        end
        if (issue2_c) begin
            if (h_type2) begin
                odd_valid_d = 1'b1;
                odd_instr_d = h_instr2;
                odd_pc_d    = h_pc2;
            end else begin
                even_valid_d = 1'b1;
                even_instr_d = h_instr2;
                even_pc_d    = h_pc2;
            end
        end
    end

    // Hold register, issue outputs and saturating stall counter
    always_ff @(posedge clk) begin
        if (reset) begin
            h_instr1         <= '0;
            h_instr2         <= '0;
            h_pc             <= '0;
            h_type1          <= 1'b0;
            h_type2          <= 1'b0;
            bus.even_valid   <= 1'b0;
            bus.odd_valid    <= 1'b0;
            bus.even_instr   <= '0;
            bus.odd_instr    <= '0;
            bus.even_pc      <= '0;
            bus.odd_pc       <= '0;
            bus.stall_cycles <= '0;
        end else begin
            if (accept_c) begin
                h_instr1 <= bus.in_instr1;
                h_instr2 <= bus.in_instr2;
                h_pc     <= bus.in_pc;
                h_type1  <= bus.in_type1;
                h_type2  <= bus.in_type2;
            end
            bus.even_valid <= even_valid_d;
            bus.odd_valid  <= odd_valid_d;
            bus.even_instr <= even_instr_d;
            bus.odd_instr  <= odd_instr_d;
            bus.even_pc    <= even_pc_d;
            bus.odd_pc     <= odd_pc_d;
            if (stall_inc_c && (bus.stall_cycles != '1))
                bus.stall_cycles <= bus.stall_cycles + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Scoreboard bench for dual_issue_ctrl: expected issues are queued per pipe when the
// issuing cycle is driven and popped when the pipe's valid is seen.
module tb_dual_issue_ctrl;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dual_issue_ctrl_if dif();
    dual_issue_ctrl dut (.clk(clk), .reset(reset), .bus(dif));

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t even_q[$];
    exp_t odd_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   exp_stall = 0;

    task automatic set_in(input logic v, input logic [31:0] i1, input logic [31:0] i2,
                          input logic t1, input logic t2, input logic [31:0] pc,
                          input logic st, input logic dep, input logic fl);
        dif.in_valid        = v;
        dif.in_instr1       = i1;
        dif.in_instr2       = i2;
        dif.in_type1        = t1;
        dif.in_type2        = t2;
        dif.in_pc           = pc;
        dif.stall           = st;
        dif.dependent_stall = dep;
        dif.flush           = fl;
    endtask

    task automatic idle_in();
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push(input logic odd, input logic [31:0] instr, input logic [31:0] pc);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        if (odd) odd_q.push_back(e);
        else     even_q.push_back(e);
    endtask

    // Scoreboard monitor: every issued instruction must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (dif.even_valid === 1'b1) begin
            total_cnt++;
            if (even_q.size() == 0) begin
                $display("FAIL even_issue: unexpected issue instr=%h pc=%h", dif.even_instr, dif.even_pc);
            end else begin
                e = even_q.pop_front();
                if (dif.even_instr !== e.instr || dif.even_pc !== e.pc)
                    $display("FAIL even_issue: got instr=%h pc=%h expected instr=%h pc=%h",
                             dif.even_instr, dif.even_pc, e.instr, e.pc);
                else pass_cnt++;
            end
        end
        if (dif.odd_valid === 1'b1) begin
            total_cnt++;
            if (odd_q.size() == 0) begin
                $display("FAIL odd_issue: unexpected issue instr=%h pc=%h", dif.odd_instr, dif.odd_pc);
            end else begin
                e = odd_q.pop_front();
                if (dif.odd_instr !== e.instr || dif.odd_pc !== e.pc)
                    $display("FAIL odd_issue: got instr=%h pc=%h expected instr=%h pc=%h",
                             dif.odd_instr, dif.odd_pc, e.instr, e.pc);
                else pass_cnt++;
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        idle_in();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_stall = 0;
        total_cnt++;
        if ({dif.even_valid, dif.odd_valid} !== 2'b00)
            $display("FAIL reset_valids: got %b%b expected 00", dif.even_valid, dif.odd_valid);
        else pass_cnt++;
        total_cnt++;
        if ({dif.even_instr, dif.odd_instr, dif.even_pc, dif.odd_pc} !== 128'd0)
            $display("FAIL reset_outputs: got %h %h %h %h expected all 0",
                     dif.even_instr, dif.odd_instr, dif.even_pc, dif.odd_pc);
        else pass_cnt++;
        total_cnt++;
        if (dif.stall_cycles !== 16'h0)
            $display("FAIL reset_stall_cycles: got %h expected 0000", dif.stall_cycles);
        else pass_cnt++;
        #1;
        total_cnt++;
        if (dif.instr_dependent_protocol !== 2'b00 || dif.in_ready !== 1'b1)
            $display("FAIL reset_handshake: got protocol=%b in_ready=%b expected 00/1",
                     dif.instr_dependent_protocol, dif.in_ready);
        else pass_cnt++;
    endtask

    task automatic test_dual();
        set_in(1'b1, 32'hA000_0001, 32'hB000_0002, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
        #1;
        total_cnt++;
        if (dif.in_ready !== 1'b1) $display("FAIL dual_accept_ready: got %b expected 1", dif.in_ready);
        else pass_cnt++;
        @(negedge clk);
        idle_in();
        push(1'b0, 32'hA000_0001, 32'h100);
        push(1'b1, 32'hB000_0002, 32'h104);
        #1;
        total_cnt++;
        if (dif.in_ready !== 1'b1) $display("FAIL dual_issue_ready: got %b expected 1", dif.in_ready);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({dif.even_valid, dif.odd_valid} !== 2'b11 || dif.even_pc !== 32'h100 || dif.odd_pc !== 32'h104)
            $display("FAIL dual_pcs: got valids=%b%b even_pc=%h odd_pc=%h expected 11 100 104",
                     dif.even_valid, dif.odd_valid, dif.even_pc, dif.odd_pc);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] i1 [3] = '{32'hC000_0001, 32'hD000_0001, 32'hE000_0001};
        logic [31:0] i2 [3] = '{32'hC000_0002, 32'hD000_0002, 32'hE000_0002};
        logic        t1 [3] = '{1'b1, 1'b0, 1'b1};
        logic [31:0] pc [3] = '{32'h400, 32'hFFFF_FFFC, 32'h800};
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                total_cnt++;
                if (dif.odd_valid !== 1'b1 || dif.odd_pc !== 32'h0)
                    $display("FAIL pc_wrap: got odd_valid=%b odd_pc=%h expected 1 00000000",
                             dif.odd_valid, dif.odd_pc);
                else pass_cnt++;
            end
            if (i < 3) set_in(1'b1, i1[i], i2[i], t1[i], ~t1[i], pc[i], 1'b0, 1'b0, 1'b0);
            else       idle_in();
            if (i > 0) begin
                push(t1[i-1], i1[i-1], pc[i-1]);
                push(~t1[i-1], i2[i-1], pc[i-1] + 32'd4);
            end
            #1;
            total_cnt++;
            if (dif.in_ready !== 1'b1) $display("FAIL b2b_ready[%0d]: got %b expected 1", i, dif.in_ready);
            else pass_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_split();
        set_in(1'b1, 32'h1111_0001, 32'h1111_0002, 1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        exp_stall++;
        #1;
        total_cnt++;
        if (dif.in_ready !== 1'b0 || dif.instr_dependent_protocol !== 2'b00)
            $display("FAIL split_pair: got in_ready=%b protocol=%b expected 0/00",
                     dif.in_ready, dif.instr_dependent_protocol);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (dif.instr_dependent_protocol !== 2'b01 || {dif.even_valid, dif.odd_valid} !== 2'b00 ||
            dif.stall_cycles !== 16'(exp_stall))
            $display("FAIL split1_state: got protocol=%b valids=%b%b stall_cycles=%0d expected 01/00/%0d",
                     dif.instr_dependent_protocol, dif.even_valid, dif.odd_valid, dif.stall_cycles, exp_stall);
        else pass_cnt++;
        idle_in();
        push(1'b1, 32'h1111_0001, 32'h200);
        #1;
        total_cnt++;
        if (dif.in_ready !== 1'b0) $display("FAIL split1_ready: got %b expected 0", dif.in_ready);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (dif.instr_dependent_protocol !== 2'b10)
            $display("FAIL split2_protocol: got %b expected 10", dif.instr_dependent_protocol);
        else pass_cnt++;
        push(1'b1, 32'h1111_0002, 32'h204);
        #1;
        total_cnt++;
        if (dif.in_ready !== 1'b1) $display("FAIL split2_ready: got %b expected 1", dif.in_ready);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (dif.instr_dependent_protocol !== 2'b00 || dif.stall_cycles !== 16'(exp_stall))
            $display("FAIL split_done: got protocol=%b stall_cycles=%0d expected 00/%0d",
                     dif.instr_dependent_protocol, dif.stall_cycles, exp_stall);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        set_in(1'b1, 32'h2222_0001, 32'h2222_0002, 1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            set_in(1'b1, 32'hDEAD_0000, 32'hDEAD_0001, 1'b1, 1'b0, 32'h900, 1'b1, 1'b0, 1'b0);
            exp_stall++;
            #1;
            total_cnt++;
            if (dif.in_ready !== 1'b0) $display("FAIL stall_ready[%0d]: got %b expected 0", k, dif.in_ready);
            else pass_cnt++;
            @(negedge clk);
            total_cnt++;
            if ({dif.even_valid, dif.odd_valid} !== 2'b00)
                $display("FAIL stall_valids[%0d]: got %b%b expected 00", k, dif.even_valid, dif.odd_valid);
            else pass_cnt++;
        end
        idle_in();
        push(1'b0, 32'h2222_0001, 32'h300);
        push(1'b1, 32'h2222_0002, 32'h304);
        #1;
        total_cnt++;
        if (dif.in_ready !== 1'b1) $display("FAIL stall_release_ready: got %b expected 1", dif.in_ready);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (dif.stall_cycles !== 16'(exp_stall))
            $display("FAIL stall_count: got %0d expected %0d", dif.stall_cycles, exp_stall);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        set_in(1'b1, 32'h3333_0001, 32'h3333_0002, 1'b0, 1'b0, 32'h500, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        exp_stall++;
        @(negedge clk);
        idle_in();
        push(1'b0, 32'h3333_0001, 32'h500);
        @(negedge clk);
        total_cnt++;
        if (dif.instr_dependent_protocol !== 2'b10)
            $display("FAIL flush_split2_protocol: got %b expected 10", dif.instr_dependent_protocol);
        else pass_cnt++;
        set_in(1'b1, 32'hDEAD_0002, 32'hDEAD_0003, 1'b0, 1'b1, 32'hA00, 1'b0, 1'b0, 1'b1);
        #1;
        total_cnt++;
        if (dif.in_ready !== 1'b0) $display("FAIL flush_ready: got %b expected 0", dif.in_ready);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({dif.even_valid, dif.odd_valid} !== 2'b00 || dif.instr_dependent_protocol !== 2'b00)
            $display("FAIL flush_idle: got valids=%b%b protocol=%b expected 00/00",
                     dif.even_valid, dif.odd_valid, dif.instr_dependent_protocol);
        else pass_cnt++;
        idle_in();
        #1;
        total_cnt++;
        if (dif.in_ready !== 1'b1) $display("FAIL flush_idle_ready: got %b expected 1", dif.in_ready);
        else pass_cnt++;
        @(negedge clk);
        // Flush beats a simultaneous stall in PAIR: pair dropped, stall not counted
        set_in(1'b1, 32'h4444_0001, 32'h4444_0002, 1'b0, 1'b1, 32'h540, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        idle_in();
        @(negedge clk);
        total_cnt++;
        if (dif.stall_cycles !== 16'(exp_stall) || dif.instr_dependent_protocol !== 2'b00)
            $display("FAIL flush_over_stall: got stall_cycles=%0d protocol=%b expected %0d/00",
                     dif.stall_cycles, dif.instr_dependent_protocol, exp_stall);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_split();
        set_in(1'b1, 32'h5555_0001, 32'h5555_0002, 1'b0, 1'b1, 32'h600, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        idle_in();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_stall = 0;
        total_cnt++;
        if ({dif.even_valid, dif.odd_valid} !== 2'b00 || dif.instr_dependent_protocol !== 2'b00 ||
            dif.stall_cycles !== 16'h0)
            $display("FAIL reset_mid_split: got valids=%b%b protocol=%b stall_cycles=%0d expected 00/00/0",
                     dif.even_valid, dif.odd_valid, dif.instr_dependent_protocol, dif.stall_cycles);
        else pass_cnt++;
        #1;
        total_cnt++;
        if (dif.in_ready !== 1'b1) $display("FAIL reset_mid_split_ready: got %b expected 1", dif.in_ready);
        else pass_cnt++;
        @(negedge clk);
        @(negedge clk);
        total_cnt++;
        if ({dif.even_valid, dif.odd_valid} !== 2'b00)
            $display("FAIL reset_mid_split_quiet: got %b%b expected 00", dif.even_valid, dif.odd_valid);
        else pass_cnt++;
    endtask

    task automatic test_saturation();
        set_in(1'b1, 32'h6666_0001, 32'h6666_0002, 1'b1, 1'b0, 32'h700, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        repeat (65535) @(negedge clk);
        total_cnt++;
        if (dif.stall_cycles !== 16'hFFFF)
            $display("FAIL sat_reach: got %h expected ffff", dif.stall_cycles);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (dif.stall_cycles !== 16'hFFFF)
            $display("FAIL sat_hold: got %h expected ffff", dif.stall_cycles);
        else pass_cnt++;
        idle_in();
        push(1'b1, 32'h6666_0001, 32'h700);
        push(1'b0, 32'h6666_0002, 32'h704);
        @(negedge clk);
    endtask

    initial begin
        idle_in();
        test_reset();
        test_dual();
        test_back_to_back();
        test_split();
        test_stall();
        test_flush();
        test_reset_mid_split();
        test_reset();
        test_saturation();
        test_reset();
        total_cnt++;
        if (even_q.size() != 0 || odd_q.size() != 0)
            $display("FAIL scoreboard_drain: got even=%0d odd=%0d pending expected 0/0",
                     even_q.size(), odd_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
